switch_control: RTL
===================

Name: switch_control

Overview:
- Per-router switch controller for the Phoenix XY NoC.
- Round-robin arbitrates among the NPORT input buffers that hold a header flit, and computes the XY output port for the selected header.
- Grants the connection if that output port is free and maintains the crossbar connection tables.
- Releases each connection when its input buffer stops sending. Sits between the input buffers and the crossbar.

Parameters:
- ADDRESS, 16'h0101: router address; [15:8] = X, [7:0] = Y.
- TAM_FLIT, 16: flit width.
- METADEFLIT, 8: half-flit width (one coordinate).
- NPORT, 5: port count. Index map: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- h  input  NPORT  header-request per input buffer.
- ack_h  output  NPORT  one-cycle header acknowledge per input.
- data  input  NPORT*TAM_FLIT  head flit of each input; port i at [i*TAM_FLIT +: TAM_FLIT].
- sender  input  NPORT  input i is still transmitting its packet.
- free  output  NPORT  output port j is unallocated.
- mux_in  output  NPORT*3  for input i, the index of the output it drives ([i*3 +: 3]).
- mux_out  output  NPORT*3  for output j, the index of the input feeding it ([j*3 +: 3]).
- in_busy  output  NPORT  input i currently owns an output.

Behaviour:
- Reset (async, reset=0) takes effect immediately:
  - ack_h = 0, free = 5'b11111, mux_in = 0, mux_out = 0, in_busy = 0.
  - FSM = S_IDLE, round-robin pointer sel = LOCAL (4), so the first search starts at EAST.
- All outputs are registered.
- FSM (one transition per clock):
  - S_IDLE: if (h & ~in_busy) != 0 -> S_ARB; else stay.
  - S_ARB: sel <= first index i with h[i] & ~in_busy[i], searching sel+1, sel+2, ... modulo NPORT. -> S_ROUTE.
  - S_ROUTE:
    - If h[sel] = 0, abort -> S_IDLE with no ack.
    - Otherwise register outport from dest = data[sel], using dx = dest[15:8], dy = dest[7:0], lx = ADDRESS[15:8], ly = ADDRESS[7:0], unsigned compares, priority in this order:
      - dx > lx -> EAST
      - dx < lx -> WEST
      - dy < ly -> SOUTH
      - dy > ly -> NORTH
      - else -> LOCAL
    - If free[outport] = 1 -> S_GRANT; else -> S_IDLE (no ack; the pointer has moved, so other requesters get a turn).
  - S_GRANT:
    - ack_h[sel] = 1 for exactly this one cycle.
    - free[outport] <= 0, in_busy[sel] <= 1, mux_in[sel] <= outport, mux_out[outport] <= sel.
    - -> S_IDLE.
- Latency: a request first sampled in S_IDLE at edge k with an uncontested free port gives ack_h high in cycle k+3.
- Minimum spacing between two grants is 4 cycles.
- Release (runs in parallel with the FSM, every cycle): for each input i with in_busy[i] = 1 and sender[i] = 0:
  - in_busy[i] <= 0, free[mux_in[i]] <= 1.
  - Table entries keep stale values; they are don't-care while free / ~in_busy.
- Simultaneous release and grant check on the same output: S_ROUTE uses the registered free, so it sees the port busy and does not grant. It retries on a later arbitration round. Release wins.
- A release and a grant on different ports in the same cycle both take effect.
- A U-turn route (output equals input index) is granted as computed; no special case.
- h is expected to stay high until ack_h. ack_h never asserts for an input whose h was low in S_ROUTE.
- Reset in any state, including S_ROUTE or S_GRANT, cancels any pending ack immediately.

Test Plan:
1. ADDRESS=16'h0101; h[4]=1, data[LOCAL]=16'h0301, sender[4]=1 -> ack_h=5'b10000 exactly 3 cycles later for 1 cycle; free=5'b11110; mux_out[EAST]=4; mux_in[LOCAL]=0; in_busy[4]=1.
2. Route table from LOCAL, one request at a time with sender dropped between requests: dest 0001->WEST, 0100->SOUTH, 0102->NORTH, 0101->LOCAL, 0201->EAST. Check mux_in[LOCAL] each time.
3. Round-robin: h[0], h[2], h[4] held high from reset with distinct free destinations, each h dropped after its own ack -> grant order 0, 2, 4.
4. Contention: input 4 holds EAST (sender[4]=1); input 1 requests dest 0201 -> no ack while busy. Drop sender[4] -> free[0]=1 next cycle; input 1 is acked on its next arbitration round; mux_out[EAST]=1.
5. Abort: h[3]=1 then dropped in the S_ROUTE cycle -> no ack_h, free unchanged, FSM returns to S_IDLE.
6. Reset asserted in S_GRANT cycle -> ack_h=0 immediately, free=5'b11111, in_busy=0. After release, first grant goes to the lowest-indexed requester.

Source files
------------

// File: rtl/switch_control.sv
// rtl/switch_control.sv - XY-routing switch controller with round-robin header arbitration
module switch_control #(
  parameter logic [15:0] ADDRESS    = 16'h0101,
  parameter int          TAM_FLIT   = 16,
  parameter int          METADEFLIT = 8,
  parameter int          NPORT      = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NPORT-1:0]          h,
  output logic [NPORT-1:0]          ack_h,
  input  logic [NPORT*TAM_FLIT-1:0] data,
  input  logic [NPORT-1:0]          sender,
  output logic [NPORT-1:0]          free,
  output logic [NPORT*3-1:0]        mux_in,
  output logic [NPORT*3-1:0]        mux_out,
  output logic [NPORT-1:0]          in_busy
);

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam logic [METADEFLIT-1:0] LX = ADDRESS[2*METADEFLIT-1:METADEFLIT];
  localparam logic [METADEFLIT-1:0] LY = ADDRESS[METADEFLIT-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

  state_t                  r_state;
  logic [2:0]              r_sel;
  logic [2:0]              r_outport;
  logic [NPORT-1:0]        r_ack;
  logic [NPORT-1:0]        r_free;
  logic [NPORT-1:0]        r_in_busy;
  logic [NPORT-1:0][2:0]   r_mux_in;
  logic [NPORT-1:0][2:0]   r_mux_out;

  logic [NPORT-1:0]        w_req;
  logic [2:0]              w_next_sel;
  logic [2:0]              w_cand;
  logic                    w_found;
  logic [TAM_FLIT-1:0]     w_flits [NPORT];
  logic [TAM_FLIT-1:0]     w_dest;
  logic [METADEFLIT-1:0]   w_dx;
  logic [METADEFLIT-1:0]   w_dy;
  logic [2:0]              w_outport;

  for (genvar g = 0; g < NPORT; g++) begin : g_flit
    assign w_flits[g] = data[g*TAM_FLIT +: TAM_FLIT];
  end

  assign w_req = h & ~r_in_busy;

  // Round-robin search starting just after the last selected input.
  always_comb begin
    w_next_sel = r_sel;
    w_cand     = r_sel;
    w_found    = 1'b0;
    for (int k = 1; k <= NPORT; k++) begin
      w_cand = 3'((int'(r_sel) + k) % NPORT);
      if (!w_found && w_req[w_cand]) begin
        w_next_sel = w_cand;
        w_found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_dest = w_flits[r_sel];
    w_dx   = w_dest[TAM_FLIT-1 -: METADEFLIT];
    w_dy   = w_dest[METADEFLIT-1:0];
    if (w_dx > LX)      w_outport = EAST;
    else if (w_dx < LX) w_outport = WEST;
    else if (w_dy < LY) w_outport = SOUTH;
    else if (w_dy > LY) w_outport = NORTH;
    else                w_outport = LOCAL;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_sel     <= 3'(NPORT - 1);
      r_outport <= '0;
      r_ack     <= '0;
      r_free    <= '1;
      r_in_busy <= '0;
      r_mux_in  <= '0;
      r_mux_out <= '0;
    end else begin
      r_ack <= '0;
      // Tables keep stale entries on release; only free/in_busy are authoritative.
      for (int i = 0; i < NPORT; i++) begin
        if (r_in_busy[i] && !sender[i]) begin
          r_in_busy[i]          <= 1'b0;
          r_free[r_mux_in[i]]   <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (|w_req) r_state <= S_ARB;
        end
        S_ARB: begin
          r_sel   <= w_next_sel;
          r_state <= S_ROUTE;
        end
        S_ROUTE: begin
          if (!h[r_sel]) begin
            r_state <= S_IDLE;
          end else begin
            r_outport <= w_outport;
            if (r_free[w_outport]) begin
              r_ack[r_sel] <= 1'b1;
              r_state      <= S_GRANT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GRANT: begin
          r_free[r_outport]    <= 1'b0;
          r_in_busy[r_sel]     <= 1'b1;
          r_mux_in[r_sel]      <= r_outport;
          r_mux_out[r_outport] <= r_sel;
          r_state              <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack_h   = r_ack;
  assign free    = r_free;
  assign in_busy = r_in_busy;
  assign mux_in  = r_mux_in;
  assign mux_out = r_mux_out;

endmodule
